// File: rtl/led_scan_monitor.sv
// led_scan_monitor
//   Watches the one-hot scan bus from the LED pattern generator. The bus is
//   synchronized and debounced into a committed value. The block then locks
//   onto the legal ping-pong sequence 01,02,...,80,40,...,01,02,... and
//   reports position, direction, end bounces, illegal steps and stalls.
//
// Parameters
//   SETTLE     consecutive cycles a new synchronized value must hold (1-15)
//   STALL_MAX  cycles without a commit before oSTALL asserts (fits 21 bits)
//
// Ports
//   iCLK     in   1  clock, all state on rising edge
//   iRST_N   in   1  asynchronous active-low reset
//   iLED     in   8  bouncing one-hot scan bus, asynchronous to iCLK
//   oPOS     out  3  index of the lit bit in the last accepted value
//   oDIR     out  1  0 = moving toward MSB, 1 = moving toward LSB
//   oVALID   out  1  high while locked onto a legal sequence
//   oEVT     out  1  one-cycle pulse per accepted step while locked
//   oSWEEPS  out  8  count of accepted end bounces (wraps)
//   oERR     out  1  sticky illegal-sequence flag
//   oSTALL   out  1  no commit for STALL_MAX cycles
module led_scan_monitor #(
    parameter int SETTLE    = 4,
    parameter int STALL_MAX = 1048576
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iLED,
    output logic [2:0] oPOS,
    output logic       oDIR,
    output logic       oVALID,
    output logic       oEVT,
    output logic [7:0] oSWEEPS,
    output logic       oERR,
    output logic       oSTALL
);
    localparam logic [3:0]  SETTLE_N = 4'(SETTLE);
    localparam logic [20:0] STALL_N  = 21'(STALL_MAX);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    // ---------------- synchronizer ----------------
    logic [7:0] sync1_reg, sync2_reg;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1_reg <= 8'h00;
            sync2_reg <= 8'h00;
        end else begin
            sync1_reg <= iLED;
            sync2_reg <= sync1_reg;
        end
    end

    // ---------------- debounce / commit ----------------
    // cand_reg tracks the most recent synchronized value; settle_reg counts
    // how many consecutive cycles it has been seen. A commit fires on the
    // cycle after the count reaches SETTLE while the value is still unchanged.
    logic [7:0]  cand_reg, commit_reg;
    logic [3:0]  settle_reg;
    logic [20:0] stall_reg;
    logic        commit;

    assign commit = (sync2_reg == cand_reg) && (settle_reg == SETTLE_N) &&
                    (cand_reg != commit_reg);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cand_reg   <= 8'h00;
            settle_reg <= 4'd0;
            commit_reg <= 8'h00;
            stall_reg  <= 21'd0;
        end else begin
            if (sync2_reg != cand_reg) begin
                cand_reg   <= sync2_reg;
                settle_reg <= 4'd1;
            end else if (settle_reg != SETTLE_N) begin
                settle_reg <= settle_reg + 4'd1;
            end
            if (commit) begin
                commit_reg <= cand_reg;
            end
            // A commit on the same edge the counter would saturate wins.
            if (commit) begin
                stall_reg <= 21'd0;
            end else if (stall_reg != STALL_N) begin
                stall_reg <= stall_reg + 21'd1;
            end
        end
    end

    assign oSTALL = (stall_reg == STALL_N);

    // ---------------- candidate decode ----------------
    // Index bit gi is the OR of every candidate bit whose position has bit gi set.
    logic [2:0][7:0] idx_terms;
    logic [2:0]      cand_idx;
    logic            cand_oh;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_idx_bit
            for (genvar gj = 0; gj < 8; gj++) begin : g_idx_term
                assign idx_terms[gi][gj] = cand_reg[gj] & (((gj >> gi) & 1) == 1);
            end
            assign cand_idx[gi] = |idx_terms[gi];
        end
    endgenerate

    assign cand_oh = (cand_reg != 8'h00) && ((cand_reg & (cand_reg - 8'd1)) == 8'h00);

    // ---------------- FSM ----------------
    state_t     state_reg, state_next;
    logic [2:0] pos_reg, pos_next;
    logic       dir_reg, dir_next;
    logic       valid_reg, valid_next;
    logic       evt_reg, evt_next;
    logic [7:0] sweeps_reg, sweeps_next;
    logic       err_reg, err_next;

    logic [2:0] exp_pos;
    logic       exp_dir, exp_bounce;
    logic       adj_up, adj_dn, lock_match;

    // Expected next step while locked; the ends reverse direction.
    always_comb begin
        exp_pos    = pos_reg;
        exp_dir    = dir_reg;
        exp_bounce = 1'b0;
        if (!dir_reg) begin
            if (pos_reg == 3'd7) begin
                exp_pos    = 3'd6;
                exp_dir    = 1'b1;
                exp_bounce = 1'b1;
            end else begin
                exp_pos = pos_reg + 3'd1;
            end
        end else begin
            if (pos_reg == 3'd0) begin
                exp_pos    = 3'd1;
                exp_dir    = 1'b0;
                exp_bounce = 1'b1;
            end else begin
                exp_pos = pos_reg - 3'd1;
            end
        end
    end

    assign adj_up     = (pos_reg != 3'd7) && (cand_idx == pos_reg + 3'd1);
    assign adj_dn     = (pos_reg != 3'd0) && (cand_idx == pos_reg - 3'd1);
    assign lock_match = cand_oh && (cand_idx == exp_pos);

    // State and output registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg  <= HUNT;
            pos_reg    <= 3'd0;
            dir_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            evt_reg    <= 1'b0;
            sweeps_reg <= 8'd0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pos_reg    <= pos_next;
            dir_reg    <= dir_next;
            valid_reg  <= valid_next;
            evt_reg    <= evt_next;
            sweeps_reg <= sweeps_next;
            err_reg    <= err_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (commit) begin
            case (state_reg)
                HUNT:    if (cand_oh) state_next = ACQ;
                ACQ:     state_next = (cand_oh && (adj_up || adj_dn)) ? LOCK : HUNT;
                LOCK:    if (!lock_match) state_next = HUNT;
                default: state_next = HUNT;
            endcase
        end
    end

    // Output logic
    always_comb begin
        pos_next    = pos_reg;
        dir_next    = dir_reg;
        valid_next  = valid_reg;
        evt_next    = 1'b0;
        sweeps_next = sweeps_reg;
        err_next    = err_reg;
        if (commit) begin
            case (state_reg)
                HUNT: begin
                    if (cand_oh) pos_next = cand_idx;
                end
                ACQ: begin
                    if (cand_oh) pos_next = cand_idx;
                    if (cand_oh && (adj_up || adj_dn)) begin
                        dir_next   = adj_dn;
                        valid_next = 1'b1;
                        evt_next   = 1'b1;
                    end
                end
                LOCK: begin
                    if (lock_match) begin
                        pos_next = exp_pos;
                        dir_next = exp_dir;
                        evt_next = 1'b1;
                        if (exp_bounce) sweeps_next = sweeps_reg + 8'd1;
                    end else begin
                        err_next   = 1'b1;
                        valid_next = 1'b0;
                    end
                end
                default: begin
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    assign oPOS    = pos_reg;
    assign oDIR    = dir_reg;
    assign oVALID  = valid_reg;
    assign oEVT    = evt_reg;
    assign oSWEEPS = sweeps_reg;
    assign oERR    = err_reg;

endmodule

// File: tb/tb_led_scan_monitor.sv
// tb_led_scan_monitor
//   Table of directed steps, hand-written latency / stall / wrap / reset
//   sequences, then randomized steps checked against a sequence-level model.
module tb_led_scan_monitor;
    localparam int SETTLE    = 4;
    localparam int STALL_MAX = 64;
    localparam int ST_HUNT   = 0;
    localparam int ST_ACQ    = 1;
    localparam int ST_LOCK   = 2;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic [7:0] iLED;
    logic [2:0] oPOS;
    logic       oDIR, oVALID, oEVT, oERR, oSTALL;
    logic [7:0] oSWEEPS;

    led_scan_monitor #(.SETTLE(SETTLE), .STALL_MAX(STALL_MAX)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iLED(iLED),
        .oPOS(oPOS), .oDIR(oDIR), .oVALID(oVALID), .oEVT(oEVT),
        .oSWEEPS(oSWEEPS), .oERR(oERR), .oSTALL(oSTALL)
    );

    always #5 iCLK = ~iCLK;

    int n_vec = 0;
    int n_bad = 0;
    int evt_total = 0;

    always @(negedge iCLK) if (oEVT === 1'b1) evt_total++;

    typedef struct {
        logic [7:0] led;
        int hold;
        int pos;
        int dir;
        int valid;
        int err;
        int sweeps;
        int evts;
    } vec_t;

    vec_t tbl[$];

    // Sequence-level model: a locked scan is a phase 0..13 on the 14-step cycle.
    int         m_state, m_pos, m_dir, m_phase, m_valid, m_err, m_sweeps, m_evts;
    logic [7:0] m_commit;

    function automatic vec_t mk(input logic [7:0] led, input int hold, input int pos,
                                input int dir, input int valid, input int err,
                                input int sweeps, input int evts);
        vec_t v;
        v.led = led; v.hold = hold; v.pos = pos; v.dir = dir;
        v.valid = valid; v.err = err; v.sweeps = sweeps; v.evts = evts;
        return v;
    endfunction

    function automatic int idx_of_phase(input int p);
        return (p <= 7) ? p : 14 - p;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic hold_val(input logic [7:0] v, input int cycles);
        iLED = v;
        repeat (cycles) @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        iLED   = 8'h00;
        repeat (3) @(posedge iCLK);
        #1 iRST_N = 1'b1;
        hold_val(8'h00, 2);
    endtask

    task automatic check_all(input string tag, input int pos, input int dir, input int valid,
                             input int err, input int sweeps, input int evts, input int base);
        chk({tag, " pos"}, oPOS, pos);
        chk({tag, " dir"}, oDIR, dir);
        chk({tag, " valid"}, oVALID, valid);
        chk({tag, " err"}, oERR, err);
        chk({tag, " sweeps"}, oSWEEPS, sweeps);
        chk({tag, " evts"}, evt_total - base, evts);
    endtask

    // Drive v (caller sits #1 after an edge) and check oEVT around edge SETTLE+3.
    task automatic lat_step(input logic [7:0] v, input string tag, input int exp_pos,
                            input int pre_stall, input int at_stall);
        iLED = v;
        repeat (SETTLE + 2) @(posedge iCLK);
        #1;
        chk({tag, " evt early"}, oEVT, 0);
        if (pre_stall >= 0) chk({tag, " stall before"}, oSTALL, pre_stall);
        @(posedge iCLK);
        #1;
        chk({tag, " evt on time"}, oEVT, 1);
        chk({tag, " pos"}, oPOS, exp_pos);
        if (at_stall >= 0) chk({tag, " stall at commit"}, oSTALL, at_stall);
        @(posedge iCLK);
        #1;
        chk({tag, " evt single"}, oEVT, 0);
        $display("latency %s led=%02h pos=%0d stall=%0d", tag, v, oPOS, oSTALL);
    endtask

    task automatic model_reset();
        m_state = ST_HUNT; m_pos = 0; m_dir = 0; m_phase = 0;
        m_valid = 0; m_err = 0; m_sweeps = 0; m_evts = 0; m_commit = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] v);
        int idx, np;
        bit oh;
        m_evts = 0;
        if (v == m_commit) return;
        m_commit = v;
        oh  = ($countones(v) == 1);
        idx = oh ? $clog2(v) : -1;
        case (m_state)
            ST_HUNT: if (oh) begin m_state = ST_ACQ; m_pos = idx; end
            ST_ACQ: begin
                if (oh && (idx == m_pos + 1 || idx == m_pos - 1)) begin
                    m_phase = (idx > m_pos) ? idx : (14 - idx) % 14;
                    m_state = ST_LOCK; m_pos = idx;
                    m_dir = (m_phase >= 8 || m_phase == 0) ? 1 : 0;
                    m_valid = 1; m_evts = 1;
                end else begin
                    m_state = ST_HUNT;
                    if (oh) m_pos = idx;
                end
            end
            default: begin
                np = (m_phase + 1) % 14;
                if (oh && idx == idx_of_phase(np)) begin
                    m_phase = np; m_pos = idx;
                    m_dir = (np >= 8 || np == 0) ? 1 : 0;
                    m_evts = 1;
                    if (np == 8 || np == 1) m_sweeps = (m_sweeps + 1) % 256;
                end else begin
                    m_err = 1; m_valid = 0; m_state = ST_HUNT;
                end
            end
        endcase
    endtask

    initial begin
        int base, phase, bounces, idx, r, glen, hold;
        logic [7:0] v, gv, legal;

        // ---------------- directed table ----------------
        tbl.push_back(mk(8'h01, 12, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(8'h02, 12, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(8'h04, 12, 2, 0, 1, 0, 0, 1));
        tbl.push_back(mk(8'h08, 12, 3, 0, 1, 0, 0, 1));
        tbl.push_back(mk(8'h10, 12, 4, 0, 1, 0, 0, 1));
        tbl.push_back(mk(8'h20, 12, 5, 0, 1, 0, 0, 1));
        tbl.push_back(mk(8'h40, 12, 6, 0, 1, 0, 0, 1));
        tbl.push_back(mk(8'h80, 12, 7, 0, 1, 0, 0, 1));
        tbl.push_back(mk(8'h40, 12, 6, 1, 1, 0, 1, 1));
        tbl.push_back(mk(8'h20, 12, 5, 1, 1, 0, 1, 1));
        tbl.push_back(mk(8'h10, 12, 4, 1, 1, 0, 1, 1));
        tbl.push_back(mk(8'h08, 12, 3, 1, 1, 0, 1, 1));
        tbl.push_back(mk(8'h04, 12, 2, 1, 1, 0, 1, 1));
        tbl.push_back(mk(8'h02, 12, 1, 1, 1, 0, 1, 1));
        tbl.push_back(mk(8'h01, 12, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(8'h02, 12, 1, 0, 1, 0, 2, 1));
        tbl.push_back(mk(8'h04, 12, 2, 0, 1, 0, 2, 1));
        tbl.push_back(mk(8'h08, 12, 3, 0, 1, 0, 2, 1));
        tbl.push_back(mk(8'h20, 12, 3, 0, 0, 1, 2, 0));   // skipped index: error
        tbl.push_back(mk(8'h40, 12, 6, 0, 0, 1, 2, 0));   // hunt -> acquire
        tbl.push_back(mk(8'h80, 12, 7, 0, 1, 1, 2, 1));   // relock, error stays
        tbl.push_back(mk(8'h40, 12, 6, 1, 1, 1, 3, 1));
        tbl.push_back(mk(8'h10,  3, 6, 1, 1, 1, 3, 0));   // glitch shorter than settle
        tbl.push_back(mk(8'h20, 12, 5, 1, 1, 1, 3, 1));

        do_reset();
        chk("reset pos", oPOS, 0);
        chk("reset dir", oDIR, 0);
        chk("reset valid", oVALID, 0);
        chk("reset evt", oEVT, 0);
        chk("reset sweeps", oSWEEPS, 0);
        chk("reset err", oERR, 0);
        chk("reset stall", oSTALL, 0);
        $display("reset pos=%0d valid=%0d err=%0d", oPOS, oVALID, oERR);

        for (int i = 0; i < tbl.size(); i++) begin
            base = evt_total;
            hold_val(tbl[i].led, tbl[i].hold);
            check_all($sformatf("tbl[%0d]", i), tbl[i].pos, tbl[i].dir, tbl[i].valid,
                      tbl[i].err, tbl[i].sweeps, tbl[i].evts, base);
            $display("vec %0d led=%02h pos=%0d dir=%0d valid=%0d err=%0d sweeps=%0d",
                     i, tbl[i].led, oPOS, oDIR, oVALID, oERR, oSWEEPS);
        end

        // ---------------- latency, glitch restart, stall ----------------
        lat_step(8'h10, "step", 4, -1, -1);
        hold_val(8'h02, 3);                           // too short to commit
        lat_step(8'h08, "glitch restart", 3, -1, -1);
        chk("glitch no err change", oERR, 1);
        repeat (62) @(posedge iCLK);
        #1;
        chk("stall before max", oSTALL, 0);
        @(posedge iCLK);
        #1;
        chk("stall at max", oSTALL, 1);
        chk("stall keeps valid", oVALID, 1);
        $display("stall stall=%0d valid=%0d", oSTALL, oVALID);
        lat_step(8'h04, "stall clear", 2, 1, 0);
        repeat (56) @(posedge iCLK);
        #1;
        lat_step(8'h02, "commit beats stall", 1, 0, 0);

        // ---------------- sweep counter wrap ----------------
        do_reset();
        hold_val(8'h01, 8);
        hold_val(8'h02, 8);
        phase = 1;
        bounces = 0;
        while (bounces < 256) begin
            phase = (phase + 1) % 14;
            idx = idx_of_phase(phase);
            v = 8'd1 << idx;
            hold_val(v, 8);
            if (phase == 8 || phase == 1) begin
                bounces++;
                if (bounces == 255) chk("sweeps at 255", oSWEEPS, 255);
            end
        end
        chk("sweeps wrapped", oSWEEPS, 0);
        chk("wrap valid", oVALID, 1);
        chk("wrap err", oERR, 0);
        $display("wrap sweeps=%0d valid=%0d", oSWEEPS, oVALID);

        // ---------------- reset mid-settle ----------------
        iLED = 8'h04;
        repeat (3) @(posedge iCLK);
        #1 iRST_N = 1'b0;
        #1;
        chk("async rst pos", oPOS, 0);
        chk("async rst valid", oVALID, 0);
        chk("async rst dir", oDIR, 0);
        chk("async rst evt", oEVT, 0);
        chk("async rst sweeps", oSWEEPS, 0);
        chk("async rst err", oERR, 0);
        chk("async rst stall", oSTALL, 0);
        repeat (2) @(posedge iCLK);
        #1 iRST_N = 1'b1;
        base = evt_total;
        hold_val(8'h04, 12);
        check_all("after rst acq", 2, 0, 0, 0, 0, 0, base);
        base = evt_total;
        hold_val(8'h08, 12);
        check_all("after rst lock", 3, 0, 1, 0, 0, 1, base);
        $display("post-reset pos=%0d valid=%0d", oPOS, oVALID);

        // ---------------- randomized steps ----------------
        for (int i = 0; i < 300; i++) begin
            if (i % 100 == 0) begin
                do_reset();
                model_reset();
            end
            if (m_state == ST_LOCK) begin
                legal = 8'd1 << idx_of_phase((m_phase + 1) % 14);
            end else if (m_pos == 0) begin
                legal = 8'h02;
            end else if (m_pos == 7) begin
                legal = 8'h40;
            end else begin
                idx = ($urandom_range(0, 1) == 1) ? m_pos + 1 : m_pos - 1;
                legal = 8'd1 << idx;
            end
            r = $urandom_range(0, 9);
            glen = 0;
            gv = 8'h00;
            case (r)
                6: v = 8'd1 << $urandom_range(0, 7);
                7: v = ($urandom_range(0, 1) == 1) ? 8'h00 : (8'h03 << $urandom_range(0, 6));
                8: begin
                    v = legal;
                    gv = 8'($urandom);
                    glen = $urandom_range(1, SETTLE - 1);
                end
                9: v = 8'($urandom);
                default: v = legal;
            endcase
            hold = $urandom_range(8, 20);
            base = evt_total;
            if (glen > 0) hold_val(gv, glen);
            hold_val(v, hold);
            model_step(v);
            check_all($sformatf("rnd[%0d]", i), m_pos, m_dir, m_valid, m_err,
                      m_sweeps, m_evts, base);
            $display("rnd %0d led=%02h glitch=%0d pos=%0d dir=%0d valid=%0d err=%0d sweeps=%0d",
                     i, v, glen, oPOS, oDIR, oVALID, oERR, oSWEEPS);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
